// File: rtl/pll_lock_sequencer.sv
// Power-up / recovery sequencer for the iCE40 PLL: holds RESETB low, waits for a
// debounced LOCK, raises pll_ready, retries on timeout and falls back to bypass.
module pll_lock_sequencer #(
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_WIDTH           = 16,
  parameter int RETRY_WIDTH         = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_lock,
  input  logic                   restart,
  output logic                   pll_resetb,
  output logic                   pll_bypass,
  output logic                   pll_ready,
  output logic                   pll_fail,
  output logic                   lock_lost,
  output logic [RETRY_WIDTH-1:0] retry_count,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0]   HOLD_LAST    = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_WIDTH-1:0] RETRY_MAX    = RETRY_WIDTH'(MAX_RETRIES);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [RETRY_WIDTH-1:0] retry_q, retry_d;
  logic                   lost_q, lost_d;
  logic                   resetb_q, resetb_d;
  logic                   bypass_q, bypass_d;
  logic                   ready_q, ready_d;
  logic                   fail_q, fail_d;
  logic                   sync1_q, lock_s_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_WIDTH'(1);
    retry_d = retry_q;
    lost_d  = lost_q;

    if (restart) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      retry_d = '0;
      lost_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        S_WAIT_LOCK: begin
          // A lock seen on the timeout cycle wins over the retry.
          if (lock_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_HOLD;
              retry_d = retry_q + RETRY_WIDTH'(1);
            end
          end
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          cnt_d = '0;
          if (!lock_s_q) begin
            state_d = S_HOLD;
            lost_d  = 1'b1;
            retry_d = '0;
          end
        end
        S_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the next state so they change on the same edge as it.
    resetb_d = (state_d == S_WAIT_LOCK) || (state_d == S_STABLE) || (state_d == S_RUN);
    ready_d  = (state_d == S_RUN);
    bypass_d = (state_d == S_FAIL);
    fail_d   = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      retry_q  <= '0;
      lost_q   <= 1'b0;
      resetb_q <= 1'b0;
      bypass_q <= 1'b0;
      ready_q  <= 1'b0;
      fail_q   <= 1'b0;
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      lost_q   <= lost_d;
      resetb_q <= resetb_d;
      bypass_q <= bypass_d;
      ready_q  <= ready_d;
      fail_q   <= fail_d;
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  assign pll_resetb  = resetb_q;
  assign pll_bypass  = bypass_q;
  assign pll_ready   = ready_q;
  assign pll_fail    = fail_q;
  assign lock_lost   = lost_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: table vectors, corner-case sequences
// and a random run compared every cycle against a phase/age reference model.
module tb_pll_lock_sequencer;

  localparam int RH = 4;
  localparam int LT = 32;
  localparam int LS = 8;
  localparam int MR = 2;

  localparam int P_HOLD   = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAIL   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_resetb, pll_bypass, pll_ready, pll_fail, lock_lost;
  logic [1:0] retry_count;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  int m_phase, m_age, m_retries;
  bit m_lost, m_sync1, m_lock_s;

  typedef struct {
    bit         lock;
    int         cycles;
    logic [2:0] st;
    bit         resetb;
    bit         ready;
    logic [1:0] retry;
  } vec_t;

  vec_t vecs[8];

  pll_lock_sequencer #(
    .RESET_HOLD_CYCLES  (RH),
    .LOCK_TIMEOUT_CYCLES(LT),
    .LOCK_STABLE_CYCLES (LS),
    .MAX_RETRIES        (MR),
    .CNT_WIDTH          (16),
    .RETRY_WIDTH        (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .restart    (restart),
    .pll_resetb (pll_resetb),
    .pll_bypass (pll_bypass),
    .pll_ready  (pll_ready),
    .pll_fail   (pll_fail),
    .lock_lost  (lock_lost),
    .retry_count(retry_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    m_phase   = P_HOLD;
    m_age     = 0;
    m_retries = 0;
    m_lost    = 1'b0;
    m_sync1   = 1'b0;
    m_lock_s  = 1'b0;
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_age   = 0;
  endtask

  // One clock edge of the reference: m_age counts completed cycles in the phase.
  task automatic model_step(input bit lock_in, input bit restart_in);
    bit seen;
    seen     = m_lock_s;
    m_lock_s = m_sync1;
    m_sync1  = lock_in;
    if (restart_in) begin
      enter(P_HOLD);
      m_retries = 0;
      m_lost    = 1'b0;
      return;
    end
    case (m_phase)
      P_HOLD: begin
        m_age++;
        if (m_age == RH) enter(P_WAIT);
      end
      P_WAIT: begin
        if (seen) enter(P_STABLE);
        else begin
          m_age++;
          if (m_age == LT) begin
            if (m_retries == MR) enter(P_FAIL);
            else begin
              m_retries++;
              enter(P_HOLD);
            end
          end
        end
      end
      P_STABLE: begin
        if (!seen) enter(P_WAIT);
        else begin
          m_age++;
          if (m_age == LS) enter(P_RUN);
        end
      end
      P_RUN: begin
        if (!seen) begin
          m_lost    = 1'b1;
          m_retries = 0;
          enter(P_HOLD);
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [9:0] model_out();
    bit rb;
    rb = (m_phase == P_WAIT) || (m_phase == P_STABLE) || (m_phase == P_RUN);
    return {3'(m_phase), 2'(m_retries), rb, m_phase == P_FAIL, m_phase == P_RUN,
            m_phase == P_FAIL, m_lost};
  endfunction

  function automatic logic [9:0] dut_out();
    return {state, retry_count, pll_resetb, pll_bypass, pll_ready, pll_fail, lock_lost};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(pll_lock, restart);
    @(negedge clk);
    cycle++;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name);
    total++;
    if (dut_out() !== model_out()) begin
      bad++;
      $display("[TB] FAIL model_%s cycle=%0d actual=%b expected=%b (state,retry,resetb,bypass,ready,fail,lost)",
               name, cycle, dut_out(), model_out());
    end
  endtask

  task automatic applyStimulus(input bit lock, input bit rst, input int n, input string name);
    pll_lock = lock;
    restart  = rst;
    for (int i = 0; i < n; i++) begin
      tick();
      restart = 1'b0;
      checkOutput(name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cycle = 0;
  endtask

  initial begin
    int waited;
    int low_cnt;
    bit saw_back;
    logic [2:0] prev_state;

    vecs[0] = '{1'b0, 3,  3'd0, 1'b0, 1'b0, 2'd0};
    vecs[1] = '{1'b0, 1,  3'd1, 1'b1, 1'b0, 2'd0};
    vecs[2] = '{1'b0, 6,  3'd1, 1'b1, 1'b0, 2'd0};
    vecs[3] = '{1'b1, 2,  3'd1, 1'b1, 1'b0, 2'd0};
    vecs[4] = '{1'b1, 1,  3'd2, 1'b1, 1'b0, 2'd0};
    vecs[5] = '{1'b1, 7,  3'd2, 1'b1, 1'b0, 2'd0};
    vecs[6] = '{1'b1, 1,  3'd3, 1'b1, 1'b1, 2'd0};
    vecs[7] = '{1'b1, 20, 3'd3, 1'b1, 1'b1, 2'd0};

    // Nominal bring-up from the vector table.
    do_reset();
    checkOutput("reset");
    check("reset_state", state, 0);
    check("reset_resetb", pll_resetb, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].lock, 1'b0, vecs[i].cycles, "vec");
      check($sformatf("vec%0d_state", i), state, vecs[i].st);
      check($sformatf("vec%0d_resetb", i), pll_resetb, vecs[i].resetb);
      check($sformatf("vec%0d_ready", i), pll_ready, vecs[i].ready);
      check($sformatf("vec%0d_retry", i), retry_count, vecs[i].retry);
    end

    // Lock never asserts: three attempts of RH+LT cycles, then FAIL.
    do_reset();
    applyStimulus(1'b0, 1'b0, 35, "nolock");
    check("nolock_e35_state", state, 1);
    check("nolock_e35_retry", retry_count, 0);
    applyStimulus(1'b0, 1'b0, 1, "nolock");
    check("nolock_e36_state", state, 0);
    check("nolock_e36_retry", retry_count, 1);
    applyStimulus(1'b0, 1'b0, 71, "nolock");
    check("nolock_e107_state", state, 1);
    check("nolock_e107_retry", retry_count, 2);
    applyStimulus(1'b0, 1'b0, 1, "nolock");
    check("nolock_fail_state", state, 4);
    check("nolock_fail_flag", pll_fail, 1);
    check("nolock_fail_bypass", pll_bypass, 1);
    check("nolock_fail_resetb", pll_resetb, 0);
    applyStimulus(1'b0, 1'b0, 200, "failhold");
    check("failhold_state", state, 4);
    applyStimulus(1'b0, 1'b1, 1, "failrestart");
    check("failrestart_state", state, 0);
    check("failrestart_fail", pll_fail, 0);
    check("failrestart_bypass", pll_bypass, 0);
    check("failrestart_retry", retry_count, 0);
    check("failrestart_lost", lock_lost, 0);

    // Glitchy lock: STABLE must fall back to WAIT_LOCK without consuming a retry.
    do_reset();
    applyStimulus(1'b0, 1'b0, 10, "glitch");
    saw_back = 1'b0;
    prev_state = state;
    for (int i = 0; i < 37; i++) begin
      applyStimulus((i < 5 || i >= 7), 1'b0, 1, "glitch");
      if (prev_state == 3'd2 && state == 3'd1) saw_back = 1'b1;
      prev_state = state;
    end
    check("glitch_back_to_wait", saw_back, 1);
    check("glitch_retry", retry_count, 0);
    check("glitch_final_state", state, 3);

    // Lock loss in RUN: a single low cycle on pll_lock.
    applyStimulus(1'b0, 1'b0, 1, "loss");
    pll_lock = 1'b1;
    waited = 1;
    while (pll_ready && waited < 6) begin
      applyStimulus(1'b1, 1'b0, 1, "loss");
      waited++;
    end
    check("loss_ready_edges_le3", (waited <= 3), 1);
    check("loss_lost", lock_lost, 1);
    check("loss_state", state, 0);
    low_cnt = 0;
    while (!pll_resetb && low_cnt < 20) begin
      low_cnt++;
      applyStimulus(1'b1, 1'b0, 1, "loss");
    end
    check("loss_resetb_low_cycles", low_cnt, RH);
    applyStimulus(1'b1, 1'b0, 20, "relock");
    check("relock_state", state, 3);
    check("relock_lost_sticky", lock_lost, 1);

    // Restart in RUN with lock held reruns the whole sequence.
    applyStimulus(1'b1, 1'b1, 1, "runrestart");
    check("runrestart_state", state, 0);
    check("runrestart_lost", lock_lost, 0);
    applyStimulus(1'b1, 1'b0, 30, "runrestart");
    check("runrestart_final_state", state, 3);

    // Asynchronous reset between clock edges while in STABLE.
    do_reset();
    applyStimulus(1'b1, 1'b0, 8, "async");
    check("async_pre_state", state, 2);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_vector", int'(dut_out()), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle = 0;
    applyStimulus(1'b1, 1'b0, 20, "async_rerun");
    check("async_rerun_state", state, 3);

    // Random lock/restart traffic against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) pll_lock = ~pll_lock;
      restart = ($urandom_range(0, 299) == 0);
      tick();
      restart = 1'b0;
      checkOutput("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Power-up and recovery sequencer for the iCE40 PLL that generates the LED display's fast clock.
- Holds the PLL in reset, releases it, and waits for a debounced LOCK.
- Then asserts pll_ready so downstream logic can release its own (locally synchronised) resets.
- On lock timeout it retries a bounded number of times, then declares failure and requests bypass.
- On lock loss it restarts the sequence.
- Runs on the PLL reference clock (board oscillator), never on the PLL output.

Parameters:
- RESET_HOLD_CYCLES, 16: cycles pll_resetb is held low per attempt (>=2).
- LOCK_TIMEOUT_CYCLES, 4096: cycles allowed in WAIT_LOCK per attempt (>=2).
- LOCK_STABLE_CYCLES, 64: consecutive synced-lock-high cycles required before ready (>=1).
- MAX_RETRIES, 3: extra attempts after the first before FAIL.
- CNT_WIDTH, 16: shared counter width; must hold max(all cycle parameters).
- RETRY_WIDTH, 2: width of retry_count; must hold MAX_RETRIES.

Ports:
- clk  in  1  PLL reference clock.
- reset  in  1  asynchronous, active-low reset.
- pll_lock  in  1  raw PLL LOCK, asynchronous to clk.
- restart  in  1  synchronous single-cycle request to rerun the sequence from HOLD.
- pll_resetb  out  1  to PLL RESETB; 0 holds the PLL in reset.
- pll_bypass  out  1  to PLL BYPASS; 1 only in FAIL.
- pll_ready  out  1  PLL output usable.
- pll_fail  out  1  retries exhausted (sticky until restart or reset).
- lock_lost  out  1  sticky; set when lock drops while in RUN.
- retry_count  out  RETRY_WIDTH  retries consumed in current sequence.
- state  out  3  HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=HOLD, cnt=0, sync flops=0.
  - pll_resetb=0, pll_bypass=0, pll_ready=0, pll_fail=0, lock_lost=0, retry_count=0.
- pll_lock passes through a 2-flop synchroniser to give lock_s; the FSM sees only lock_s.
- All outputs are registered and update on the same edge as the state transition:
  - pll_resetb=1 in WAIT_LOCK, STABLE, RUN.
  - pll_ready=1 only in RUN.
  - pll_bypass=1 and pll_fail=1 only in FAIL.
- Counter cnt is cleared on every state entry.
- HOLD:
  - Increment cnt.
  - At cnt==RESET_HOLD_CYCLES-1, go to WAIT_LOCK.
  - pll_resetb is therefore low exactly RESET_HOLD_CYCLES cycles.
- WAIT_LOCK:
  - lock_s=1: go to STABLE.
  - Else at cnt==LOCK_TIMEOUT_CYCLES-1 (timeout):
    - If retry_count==MAX_RETRIES, go to FAIL.
    - Otherwise retry_count++ and go to HOLD.
  - lock_s=1 on the timeout cycle takes priority (go to STABLE, no retry).
- STABLE:
  - lock_s=0: return to WAIT_LOCK with a fresh timeout. retry_count is unchanged.
  - Otherwise at cnt==LOCK_STABLE_CYCLES-1, go to RUN.
- RUN:
  - lock_s=0: set lock_lost, clear retry_count, go to HOLD. pll_ready falls on that edge.
- FAIL:
  - Terminal until restart or reset.
  - pll_resetb=0, pll_bypass=1.
- restart=1 has highest priority in every state:
  - Next state is HOLD, cnt=0, retry_count=0, pll_fail=0.
  - lock_lost is also cleared.
  - restart during HOLD restarts the hold count.
- Latency: pll_lock rising (held high) to pll_ready rising is 2 + LOCK_STABLE_CYCLES + 1 clk edges, ±1 for synchroniser sampling.
- Lock loss to pll_ready falling is ≤3 clk edges.
- Counter never wraps; all compares are exact equality within CNT_WIDTH.

Test Plan:
Parameters for all scenarios: RESET_HOLD_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal bring-up: release reset, raise pll_lock 10 cycles later and hold it -> pll_resetb rises exactly 4 edges after reset release; state goes 0→1→2→3; pll_ready rises 11±1 edges after pll_lock; retry_count=0.
- Lock never asserts -> three attempts of 36 cycles each; retry_count steps 0→1→2; state=FAIL at ~108 cycles after reset release; pll_fail=1, pll_bypass=1, pll_resetb=0; stays there for ≥200 cycles.
- Glitchy lock: pll_lock high 5 cycles, low 2, then high continuously -> state returns 2→1 on the glitch; no pll_ready until 8 consecutive lock_s highs; retry_count stays 0.
- Lock loss in RUN: drop pll_lock for 1 cycle -> pll_ready=0 within 3 edges; lock_lost=1; state=HOLD; pll_resetb low exactly 4 cycles; re-lock then reaches RUN with lock_lost still 1.
- Restart handling:
  - Pulse restart in FAIL -> state=HOLD next edge; pll_fail=0, pll_bypass=0, retry_count=0, lock_lost=0.
  - Pulse restart in RUN with lock held -> full sequence reruns.
- Asynchronous reset asserted mid-STABLE, between clk edges -> all outputs reach their reset values immediately, with no clk edge; sequence restarts on release.
